// File: rtl/m2s_serve_responder_if.sv
// Request/serve FIFO pair seen by the m2s responder.
// slave = responder side, master = FIFO side.
interface m2s_serve_responder_if;
    localparam int unsigned REQ_W   = 74;
    localparam int unsigned SERVE_W = 52;

    logic               req_empty;
    logic               req_rd_en;
    logic [REQ_W-1:0]   req_data;
    logic               serve_full;
    logic               serve_wr_en;
    logic [SERVE_W-1:0] serve_data;

    modport slave (
        input  req_empty, req_data, serve_full,
        output req_rd_en, serve_wr_en, serve_data
    );

    modport master (
        output req_empty, req_data, serve_full,
        input  req_rd_en, serve_wr_en, serve_data
    );
endinterface

// File: rtl/m2s_serve_responder.sv
// Responder for the multi2sim FIFO pair: pops one request, executes it on a word memory,
// pushes the response after LATENCY wait cycles. Optional range check: M2S_RESP_ADDR_CHECK_EN.
module m2s_serve_responder #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    m2s_serve_responder_if.slave bus,
    output logic                 busy,
    output logic [15:0]          served_count,
    output logic                 addr_err
);
    localparam int unsigned ADDR_W    = 31;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ID_W      = 10;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned SERVE_W   = 52;
    localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [DATA_W-1:0] OOR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t                    r_state;
    logic                      r_req_rd_en;
    logic                      r_busy;
    logic [SERVE_W-1:0]        r_serve_data;
    logic [15:0]               r_served_count;
    logic [CNT_W-1:0]          r_cnt;
    logic [DATA_W-1:0]         r_mem [MEM_DEPTH];

    logic                      w_rw;
    logic [ADDR_W-1:0]         w_addr;
    logic [DATA_W-1:0]         w_wdata;
    logic [ID_W-1:0]           w_id;
    logic [MEM_ADDR_WIDTH-1:0] w_index;
    logic [DATA_W-1:0]         w_rdata;
    logic [DATA_W-1:0]         w_ret_data;
    logic                      w_oor;
    logic                      w_mem_we;

    assign w_rw    = bus.req_data[73];
    assign w_addr  = bus.req_data[72:42];
    assign w_wdata = bus.req_data[41:10];
    assign w_id    = bus.req_data[9:0];
    assign w_index = w_addr[MEM_ADDR_WIDTH-1:0];
    assign w_rdata = r_mem[w_index];

`ifdef M2S_RESP_ADDR_CHECK_EN
    logic r_addr_err;

    assign w_oor    = |w_addr[ADDR_W-1:MEM_ADDR_WIDTH];
    assign addr_err = r_addr_err;
`else
    // Upper address bits alias onto the memory and are intentionally ignored.
    logic w_unused;

    assign w_unused = ^w_addr[ADDR_W-1:MEM_ADDR_WIDTH];
    assign w_oor    = 1'b0;
    assign addr_err = 1'b0;
`endif

    assign w_ret_data = w_oor ? OOR_DATA : (w_rw ? w_wdata : w_rdata);
    assign w_mem_we   = (r_state == S_CAPTURE) && w_rw && !w_oor;

    // Memory is never cleared; reset forces IDLE, which blocks any pending write.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_index] <= w_wdata;
        end
    end

    // Access sequencer: IDLE -> POP -> CAPTURE -> WAIT -> PUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_req_rd_en    <= 1'b0;
            r_busy         <= 1'b0;
            r_serve_data   <= '0;
            r_served_count <= '0;
            r_cnt          <= '0;
`ifdef M2S_RESP_ADDR_CHECK_EN
            r_addr_err     <= 1'b0;
`endif
        end else begin
            r_req_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.req_empty) begin
                        r_state     <= S_POP;
                        r_req_rd_en <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_POP: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_serve_data <= {w_ret_data, w_id, w_id + ID_W'(1)};
                    r_cnt        <= CNT_W'(LATENCY - 1);
                    r_state      <= S_WAIT;
`ifdef M2S_RESP_ADDR_CHECK_EN
                    if (w_oor) begin
                        r_addr_err <= 1'b1;
                    end
`endif
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!bus.serve_full) begin
                        r_served_count <= r_served_count + 16'd1;
                        if (!bus.req_empty) begin
                            r_state     <= S_POP;
                            r_req_rd_en <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write enable must drop in the same cycle serve_full rises, so it is decoded, not registered.
    assign bus.serve_wr_en = (r_state == S_PUSH) && !bus.serve_full;
    assign bus.req_rd_en   = r_req_rd_en;
    assign bus.serve_data  = r_serve_data;
    assign busy            = r_busy;
    assign served_count    = r_served_count;
endmodule

// File: tb/tb_m2s_serve_responder.sv
// Bench for m2s_serve_responder: FIFO models on both sides plus a memory/response reference model.
module tb_m2s_serve_responder;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 4;
    localparam int          PER = LAT + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] served_count;
    logic        addr_err;

    m2s_serve_responder_if bus();

    m2s_serve_responder #(.MEM_ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .served_count (served_count),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Request FIFO: data_out registered on the read-enable edge.
    logic [73:0] req_arr [64];
    int n_push = 0;
    int n_pop  = 0;
    assign bus.req_empty = (n_push == n_pop);
    always @(posedge clk) begin
        if (bus.req_rd_en === 1'b1 && n_pop < n_push) begin
            bus.req_data <= req_arr[n_pop];
            n_pop        <= n_pop + 1;
        end
    end

    // Serve FIFO side monitor, sampled mid low phase.
    logic [51:0] got_d [64];
    int          got_c [64];
    int n_got = 0;
    int n_rd  = 0;
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b1) begin
            if (bus.serve_wr_en === 1'b1 && n_got < 64) begin
                got_d[n_got] = bus.serve_data;
                got_c[n_got] = cyc;
                n_got++;
            end
            if (bus.req_rd_en === 1'b1) n_rd++;
        end
    end

    // Reference model: accesses complete in order, so responses are computed at enqueue time.
    logic [31:0] m_mem [256];
    bit          m_vld [256];
    bit          exp_addr_err = 1'b0;
    logic [51:0] exp_d [64];
    int n_exp = 0;
    int n_seen = 0;
    int exp_served = 0;

    function automatic logic [51:0] model(input bit rw, input logic [30:0] addr,
                                          input logic [31:0] d, input logic [9:0] id);
        int          idx;
        bit          oor;
        logic [31:0] rd;
        int          nid;
        idx = int'(addr % 31'(1 << AW));
`ifdef M2S_RESP_ADDR_CHECK_EN
        oor = (addr >= 31'(1 << AW));
`else
        oor = 1'b0;
`endif
        rd = rw ? d : m_mem[idx];
        if (oor) begin
            rd = 32'hDEAD_BEEF;
            exp_addr_err = 1'b1;
        end else if (rw) begin
            m_mem[idx] = d;
            m_vld[idx] = 1'b1;
        end
        nid = (int'(id) + 1) % 1024;
        return {rd, id, 10'(nid)};
    endfunction

    task automatic push_req(input bit rw, input logic [30:0] addr, input logic [31:0] d,
                            input logic [9:0] id, input bit keep);
        logic [51:0] r;
        r = model(rw, addr, d, id);
        req_arr[n_push] = {rw, addr, d, id};
        n_push++;
        if (keep) begin
            exp_d[n_exp] = r;
            n_exp++;
            exp_served++;
        end
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int b;
        b = 0;
        while (n_got < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        ok = (n_got >= n);
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b0;
        bus.serve_full = 1'b0;
        repeat (3) @(negedge clk);
        chk++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
        chk++; if (served_count !== 16'd0) begin err++; $display("FAIL reset_count got %0d want 0", served_count); end
        chk++; if (addr_err !== 1'b0) begin err++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
        chk++; if (bus.serve_data !== 52'd0) begin err++; $display("FAIL reset_serve_data got %h want 0", bus.serve_data); end
        chk++; if (bus.req_rd_en !== 1'b0) begin err++; $display("FAIL reset_rd_en got %b want 0", bus.req_rd_en); end
        chk++; if (bus.serve_wr_en !== 1'b0) begin err++; $display("FAIL reset_wr_en got %b want 0", bus.serve_wr_en); end
        reset = 1'b1;
        @(negedge clk);
        // Write whose capture completes before the mid-WAIT reset; response is dropped.
        push_req(1'b1, 31'h7F, $urandom, 10'($urandom), 1'b0);
        repeat (4) @(negedge clk);
        chk++; if (busy !== 1'b1) begin err++; $display("FAIL midwait_busy got %b want 1", busy); end
        reset = 1'b0;
        #1;
        chk++; if (busy !== 1'b0) begin err++; $display("FAIL async_busy got %b want 0", busy); end
        chk++; if (bus.serve_data !== 52'd0) begin err++; $display("FAIL async_serve_data got %h want 0", bus.serve_data); end
        chk++; if (bus.serve_wr_en !== 1'b0) begin err++; $display("FAIL async_wr_en got %b want 0", bus.serve_wr_en); end
        @(negedge clk);
        reset = 1'b1;
        exp_served = 0;
        exp_addr_err = 1'b0;
        base = n_got;
        repeat (12) begin
            @(negedge clk);
            chk++; if (busy !== 1'b0) begin err++; $display("FAIL post_reset_busy got %b want 0", busy); end
        end
        chk++; if (n_got !== base) begin err++; $display("FAIL dropped_push got %0d pushes want %0d", n_got, base); end
    endtask

    task automatic test_write_read();
        int c, k;
        bit ok;
        @(negedge clk);
        c = cyc;
        k = n_got;
        push_req(1'b1, 31'h05, 32'hCAFE_0001, 10'd3, 1'b1);
        push_req(1'b0, 31'h05, 32'h0, 10'd4, 1'b1);
        wait_got(k + 2, 100, ok);
        chk++; if (!ok) begin err++; $display("FAIL wr_rd_timeout got %0d pushes want %0d", n_got - k, 2); end
        if (ok) begin
            chk++; if (got_d[k] !== {32'hCAFE_0001, 10'd3, 10'd4}) begin err++; $display("FAIL wr_resp got %h want %h", got_d[k], {32'hCAFE_0001, 10'd3, 10'd4}); end
            chk++; if (got_d[k+1] !== {32'hCAFE_0001, 10'd4, 10'd5}) begin err++; $display("FAIL rd_resp got %h want %h", got_d[k+1], {32'hCAFE_0001, 10'd4, 10'd5}); end
            chk++; if (got_c[k] - c !== PER) begin err++; $display("FAIL first_latency got %0d want %0d", got_c[k] - c, PER); end
            chk++; if (got_c[k+1] - got_c[k] !== PER) begin err++; $display("FAIL wr_rd_spacing got %0d want %0d", got_c[k+1] - got_c[k], PER); end
        end
        chk++; if (served_count !== 16'd2) begin err++; $display("FAIL wr_rd_count got %0d want 2", served_count); end
        n_seen = n_exp;
    endtask

    task automatic test_id_wrap();
        int k;
        bit ok;
        @(negedge clk);
        k = n_got;
        push_req(1'b1, 31'(8'($urandom)), $urandom, 10'd1023, 1'b1);
        wait_got(k + 1, 100, ok);
        chk++; if (!ok) begin err++; $display("FAIL id_wrap_timeout got %0d pushes want 1", n_got - k); end
        if (ok) begin
            chk++; if (got_d[k][9:0] !== 10'd0) begin err++; $display("FAIL id_wrap_next got %0d want 0", got_d[k][9:0]); end
            chk++; if (got_d[k] !== exp_d[n_seen]) begin err++; $display("FAIL id_wrap_resp got %h want %h", got_d[k], exp_d[n_seen]); end
        end
        n_seen = n_exp;
    endtask

    task automatic test_backpressure();
        int k, rdb;
        bit ok;
        logic [51:0] sd;
        @(negedge clk);
        bus.serve_full = 1'b1;
        k = n_got;
        push_req(1'b0, 31'h05, 32'h0, 10'($urandom), 1'b1);
        repeat (PER) @(negedge clk);
        sd = bus.serve_data;
        push_req(1'b1, 31'h06, $urandom, 10'($urandom), 1'b1);
        rdb = n_rd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk++; if (bus.serve_wr_en !== 1'b0) begin err++; $display("FAIL stall_wr_en cycle %0d got %b want 0", i, bus.serve_wr_en); end
            chk++; if (bus.serve_data !== sd) begin err++; $display("FAIL stall_data cycle %0d got %h want %h", i, bus.serve_data, sd); end
        end
        chk++; if (busy !== 1'b1) begin err++; $display("FAIL stall_busy got %b want 1", busy); end
        chk++; if (n_rd !== rdb) begin err++; $display("FAIL stall_rd_en got %0d pulses want 0", n_rd - rdb); end
        chk++; if (n_got !== k) begin err++; $display("FAIL stall_push got %0d pushes want 0", n_got - k); end
        bus.serve_full = 1'b0;
        wait_got(k + 2, 100, ok);
        chk++; if (!ok) begin err++; $display("FAIL bp_timeout got %0d pushes want 2", n_got - k); end
        if (ok) begin
            for (int i = 0; i < 2; i++) begin
                chk++; if (got_d[k+i] !== exp_d[n_seen+i]) begin err++; $display("FAIL bp_resp %0d got %h want %h", i, got_d[k+i], exp_d[n_seen+i]); end
            end
            chk++; if (got_d[k] !== sd) begin err++; $display("FAIL bp_held_data got %h want %h", got_d[k], sd); end
            chk++; if (got_c[k+1] - got_c[k] !== PER) begin err++; $display("FAIL bp_spacing got %0d want %0d", got_c[k+1] - got_c[k], PER); end
        end
        n_seen = n_exp;
    endtask

    task automatic test_back_to_back();
        int c, k, rdb, idx;
        bit ok, rw;
        for (int round = 0; round < 2; round++) begin
            @(negedge clk);
            c = cyc;
            k = n_got;
            rdb = n_rd;
            for (int i = 0; i < 8; i++) begin
                idx = 32 + int'($urandom_range(0, 7));
                rw = 1'($urandom) | !m_vld[idx];
                push_req(rw, 31'(idx), $urandom, 10'($urandom), 1'b1);
            end
            wait_got(k + 8, 8 * PER + 20, ok);
            repeat (3) @(negedge clk);
            chk++; if (!ok) begin err++; $display("FAIL b2b_timeout got %0d pushes want 8", n_got - k); end
            chk++; if (n_rd - rdb !== 8) begin err++; $display("FAIL b2b_rd_pulses got %0d want 8", n_rd - rdb); end
            if (ok) begin
                chk++; if (got_c[k] - c !== PER) begin err++; $display("FAIL b2b_latency got %0d want %0d", got_c[k] - c, PER); end
                for (int i = 0; i < 8; i++) begin
                    chk++; if (got_d[k+i] !== exp_d[n_seen+i]) begin err++; $display("FAIL b2b_resp %0d got %h want %h", i, got_d[k+i], exp_d[n_seen+i]); end
                    if (i > 0) begin
                        chk++; if (got_c[k+i] - got_c[k+i-1] !== PER) begin err++; $display("FAIL b2b_spacing %0d got %0d want %0d", i, got_c[k+i] - got_c[k+i-1], PER); end
                    end
                end
            end
            n_seen = n_exp;
        end
    endtask

    task automatic test_addr_range();
        int k;
        bit ok;
        logic [31:0] a, b, want_oor, want_rd;
        a = $urandom;
        b = ~a;
        @(negedge clk);
        k = n_got;
        push_req(1'b1, 31'h000, a, 10'd7, 1'b1);
        push_req(1'b1, 31'h100, b, 10'd8, 1'b1);
        push_req(1'b0, 31'h000, 32'h0, 10'd9, 1'b1);
`ifdef M2S_RESP_ADDR_CHECK_EN
        want_oor = 32'hDEAD_BEEF;
        want_rd  = a;
`else
        want_oor = b;
        want_rd  = b;
`endif
        wait_got(k + 3, 100, ok);
        chk++; if (!ok) begin err++; $display("FAIL range_timeout got %0d pushes want 3", n_got - k); end
        if (ok) begin
            chk++; if (got_d[k+1][51:20] !== want_oor) begin err++; $display("FAIL range_wr_data got %h want %h", got_d[k+1][51:20], want_oor); end
            chk++; if (got_d[k+2][51:20] !== want_rd) begin err++; $display("FAIL range_rd_data got %h want %h", got_d[k+2][51:20], want_rd); end
            for (int i = 0; i < 3; i++) begin
                chk++; if (got_d[k+i] !== exp_d[n_seen+i]) begin err++; $display("FAIL range_resp %0d got %h want %h", i, got_d[k+i], exp_d[n_seen+i]); end
            end
        end
        chk++; if (addr_err !== exp_addr_err) begin err++; $display("FAIL addr_err got %b want %b", addr_err, exp_addr_err); end
        n_seen = n_exp;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_id_wrap();
        test_backpressure();
        test_back_to_back();
        test_addr_range();
        repeat (2) @(negedge clk);
        chk++; if (served_count !== 16'(exp_served)) begin err++; $display("FAIL final_count got %0d want %0d", served_count, exp_served); end
        chk++; if (busy !== 1'b0) begin err++; $display("FAIL final_busy got %b want 0", busy); end
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
